lux_irq_event_reader: RTL and testbench

//  Avalon-MM master that services the lux-sensor edge-capture PIO. It programs the PIO irq mask, waits
//  for irq, then reads and clears the edge-capture register, reads the pin level, and pushes a

---
 rtl/lux_irq_event_reader.sv | 163 ++++++++++++++++
 tb/tb_lux_irq_event_reader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/lux_irq_event_reader.sv
// lux_irq_event_reader: Avalon-MM master that services the lux-sensor edge-capture PIO.
// It keeps the PIO irq mask in step with en_i. On each irq it reads and clears the
// edge-capture register, reads the pin level, and pushes a {timestamp, level} record
// into a small event FIFO.
// Optional feature: define LUX_EVENT_TIMESTAMP_EN to build the free-running timestamp
// counter. Without it, the timestamp field of every record is constant zero.
module lux_irq_event_reader #(
    parameter int DEPTH = 8,
    parameter int TS_W  = 24
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            en_i,
    input  logic            irq_in_i,
    output logic [1:0]      m_address_o,
    output logic            m_chipselect_o,
    output logic            m_write_n_o,
    output logic [31:0]     m_writedata_o,
    input  logic [31:0]     m_readdata_i,
    output logic            ev_valid_o,
    input  logic            ev_ready_i,
    output logic [TS_W:0]   ev_data_o,
    output logic [7:0]      drop_count_o,
    output logic            busy_o
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_MASK, S_RD_CAP_A, S_RD_CAP_D, S_CLR, S_RD_LVL_A, S_RD_LVL_D, S_PUSH
    } state_t;

    state_t            state_q, state_d;
    logic              mask_q, mask_d;
    logic              lvl_q, lvl_d;
    logic [TS_W-1:0]   ts_cap_q, ts_cap_d;
    logic [TS_W-1:0]   ts_now;

    logic [TS_W:0]     mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, rd_ptr_q;
    logic [7:0]        drop_q;
    logic              fifo_empty, fifo_full, pop, push_req, push_ok, drop_ev;

`ifdef LUX_EVENT_TIMESTAMP_EN
    logic [TS_W-1:0]   ts_cnt_q;

    // Free-running timestamp; wraps naturally at 2^TS_W.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ts_cnt_q <= '0;
        else         ts_cnt_q <= ts_cnt_q + {{(TS_W-1){1'b0}}, 1'b1};
    end
    assign ts_now = ts_cnt_q;
`else
    assign ts_now = '0;
`endif

    // State and service-context registers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            mask_q   <= 1'b0;
            lvl_q    <= 1'b0;
            ts_cap_q <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            lvl_q    <= lvl_d;
            ts_cap_q <= ts_cap_d;
        end
    end

    // Next-state logic and bus drive; bus is decoded from state so reset idles it at once.
    always_comb begin
        state_d        = state_q;
        mask_d         = mask_q;
        lvl_d          = lvl_q;
        ts_cap_d       = ts_cap_q;
        m_address_o    = 2'd0;
        m_chipselect_o = 1'b0;
        m_write_n_o    = 1'b1;
        m_writedata_o  = 32'd0;
        case (state_q)
            S_IDLE: begin
                // A pending mask update wins over an irq.
                if (en_i != mask_q) begin
                    state_d = S_MASK;
                end else if (irq_in_i && en_i) begin
                    state_d  = S_RD_CAP_A;
                    ts_cap_d = ts_now;
                end
            end
            S_MASK: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 2'd2;
                m_writedata_o  = {31'd0, en_i};
                mask_d         = en_i;
                state_d        = S_IDLE;
            end
            S_RD_CAP_A: begin
                m_chipselect_o = 1'b1;
                m_address_o    = 2'd3;
                state_d        = S_RD_CAP_D;
            end
            S_RD_CAP_D: begin
                // Nothing captured means a spurious irq: drop it silently.
                state_d = m_readdata_i[0] ? S_CLR : S_IDLE;
            end
            S_CLR: begin
                m_chipselect_o = 1'b1;
                m_write_n_o    = 1'b0;
                m_address_o    = 2'd3;
                state_d        = S_RD_LVL_A;
            end
            S_RD_LVL_A: begin
                m_chipselect_o = 1'b1;
                m_address_o    = 2'd0;
                state_d        = S_RD_LVL_D;
            end
            S_RD_LVL_D: begin
                lvl_d   = m_readdata_i[0];
                state_d = S_PUSH;
            end
            S_PUSH: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign push_req   = (state_q == S_PUSH);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = ev_ready_i && !fifo_empty;
    // A same-cycle pop frees the slot the push needs.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign drop_ev    = push_req && fifo_full && !pop;

    // FIFO pointers and saturating drop counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= 8'd0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (pop)     rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
            if (drop_ev && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= {ts_cap_q, lvl_q};
    end

    assign ev_valid_o   = !fifo_empty;
    assign ev_data_o    = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign drop_count_o = drop_q;

endmodule

// File: tb/tb_lux_irq_event_reader.sv
// Bench for lux_irq_event_reader: a PIO slave model, a queue-based event model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_lux_irq_event_reader;
    localparam int DEPTH = 8;
    localparam int TS_W  = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1, ev_ready = 1'b0;
    logic irq;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  m_address;
    logic        m_cs, m_write_n, ev_valid, busy;
    logic [31:0] m_wd;
    logic [TS_W:0] ev_data;
    logic [7:0]  drop_count;

    lux_irq_event_reader #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
        .clk_i(clk), .reset_i(rst), .en_i(en), .irq_in_i(irq),
        .m_address_o(m_address), .m_chipselect_o(m_cs), .m_write_n_o(m_write_n),
        .m_writedata_o(m_wd), .m_readdata_i(rdata),
        .ev_valid_o(ev_valid), .ev_ready_i(ev_ready), .ev_data_o(ev_data),
        .drop_count_o(drop_count), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // PIO slave model
    logic pin = 1'b1, cap = 1'b0, pio_mask = 1'b0, force_irq = 1'b0;
    int   edge_cnt = 0, edge_seen = 0;
    logic b_cs = 1'b0, b_wn = 1'b1;
    logic [1:0] b_addr = 2'd0;
    logic [31:0] b_wd = 32'd0;
    int   cyc = 0;

    assign irq = (pio_mask & cap) | force_irq;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
        if (b_cs && !b_wn && b_addr == 2'd2) pio_mask <= b_wd[0];
        // Clear write wins over a simultaneous edge.
        if (b_cs && !b_wn && b_addr == 2'd3) cap <= 1'b0;
        else if (edge_cnt != edge_seen)      cap <= 1'b1;
        edge_seen <= edge_cnt;
        if (b_cs && b_wn)
            rdata <= (b_addr == 2'd0) ? {31'd0, pin} :
                     (b_addr == 2'd3) ? {31'd0, cap} :
                     (b_addr == 2'd2) ? {31'd0, pio_mask} : 32'd0;
    end

    // Event model: records expected in the FIFO, plus the drop counter.
    logic [TS_W:0] mq[$];
    int   m_drop = 0;
    logic pend = 1'b0, pend_lvl = 1'b0;
    logic [TS_W-1:0] pend_ts;
    int   pend_due = 0;
    int   wr2_cnt = 0, wr3_cnt = 0, rd3_cnt = 0, rd0_cnt = 0, bus_cnt = 0;
    int   wr2_cyc = 0, clr_cyc = 0;
    logic [31:0] wr2_data = 32'd0;

    // Compare DUT with model every cycle, log bus transactions, then advance the model.
    always @(negedge clk) begin
        logic popm;
        logic [TS_W:0] rec;
        b_cs = m_cs; b_wn = m_write_n; b_addr = m_address; b_wd = m_wd;
        if (!rst) begin
            if (!m_cs) chk("bus_idle", {m_address, m_write_n, m_wd}, {2'b00, 1'b1, 32'd0});
            chk("ev_valid", ev_valid, mq.size() > 0);
            if (mq.size() > 0) chk("ev_data", ev_data, mq[0]);
            chk("drop_count", drop_count, m_drop);
            if (m_cs) begin
                bus_cnt++;
                $display("cyc %0d bus %s addr=%0d data=%0h", cyc, m_write_n ? "rd" : "wr", m_address, m_wd);
            end
            if (m_cs && !m_write_n && m_address == 2'd2) begin
                wr2_cnt++; wr2_data = m_wd; wr2_cyc = cyc;
            end
            if (m_cs && !m_write_n && m_address == 2'd3) begin
                wr3_cnt++; clr_cyc = cyc;
                chk("clr_data", m_wd, 0);
                pend = 1'b1; pend_ts = TS_W'(cyc - 3); pend_due = cyc + 3;
            end
            if (m_cs && m_write_n && m_address == 2'd3) rd3_cnt++;
            if (m_cs && m_write_n && m_address == 2'd0) begin
                rd0_cnt++; pend_lvl = pin;
            end
            popm = ev_ready && (mq.size() > 0);
            if (pend && cyc == pend_due) begin
                pend = 1'b0;
`ifdef LUX_EVENT_TIMESTAMP_EN
                rec = {pend_ts, pend_lvl};
`else
                rec = {{TS_W{1'b0}}, pend_lvl};
`endif
                if (mq.size() - (popm ? 1 : 0) < DEPTH) mq.push_back(rec);
                else if (m_drop != 255) m_drop++;
            end
            if (popm) mq.delete(0);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic make_edge(input logic lvl);
        pin = lvl;
        edge_cnt++;
    endtask

    task automatic service(input logic lvl);
        int k;
        make_edge(lvl);
        step(2);
        k = 0;
        while (busy && k < 40) begin step(1); k++; end
        if (k >= 40) chk("service_timeout", 1, 0);
        step(1);
    endtask

    initial begin
        int c_rd3, c_wr3, c_rd0, w2, bc, n;
        int ts0;
        // Reset state
        step(3);
        chk("rst_cs", m_cs, 0);
        chk("rst_write_n", m_write_n, 1);
        chk("rst_addr", m_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", ev_valid, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_data", ev_data, 0);
        rst = 1'b0;
        step(6);
        // 1: one mask write of 1 after reset
        chk("t1_wr2_cnt", wr2_cnt, 1);
        chk("t1_wr2_data", wr2_data, 1);
        chk("t1_bus_cnt", bus_cnt, 1);
        chk("t1_busy", busy, 0);
        chk("t1_valid", ev_valid, 0);
        // 2: falling edge, level 0, latency 7
        c_rd3 = rd3_cnt; c_wr3 = wr3_cnt; c_rd0 = rd0_cnt;
        make_edge(1'b0);
        step(1);
        ts0 = cyc;
        chk("t2_irq", irq, 1);
        step(6);
        chk("t2_valid_c6", ev_valid, 0);
        step(1);
        chk("t2_valid_c7", ev_valid, 1);
        chk("t2_level", ev_data[0], 0);
`ifdef LUX_EVENT_TIMESTAMP_EN
        chk("t2_ts", ev_data[TS_W:1], TS_W'(ts0));
`else
        chk("t2_ts", ev_data[TS_W:1], 0);
`endif
        chk("t2_busy", busy, 0);
        chk("t2_rd3", rd3_cnt, c_rd3 + 1);
        chk("t2_wr3", wr3_cnt, c_wr3 + 1);
        chk("t2_rd0", rd0_cnt, c_rd0 + 1);
        ev_ready = 1'b1; step(1); ev_ready = 1'b0;
        chk("t2_drained", ev_valid, 0);
        // 3: spurious irq
        c_rd3 = rd3_cnt; c_wr3 = wr3_cnt;
        force_irq = 1'b1; step(1); force_irq = 1'b0;
        step(5);
        chk("t3_busy", busy, 0);
        chk("t3_rd3", rd3_cnt, c_rd3 + 1);
        chk("t3_wr3", wr3_cnt, c_wr3);
        chk("t3_valid", ev_valid, 0);
        // 4: 11 events with no consumer
        for (int i = 0; i < 11; i++) service(logic'(i % 2));
        chk("t4_drop", drop_count, 3);
        ev_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("t4_pop_valid", ev_valid, 1);
            chk("t4_pop_lvl", ev_data[0], logic'(i % 2));
            step(1);
        end
        ev_ready = 1'b0;
        chk("t4_empty", ev_valid, 0);
        // 5: full FIFO, push and pop together, then saturation
        for (int i = 0; i < 8; i++) service(logic'(i % 2));
        make_edge(1'b1);
        step(1);
        step(6);
        ev_ready = 1'b1; step(1); ev_ready = 1'b0;
        chk("t5_head", ev_data[0], 1);
        chk("t5_drop", drop_count, 3);
        step(2);
        for (int i = 0; i < 260; i++) service(logic'(i % 2));
        chk("t5_sat", drop_count, 255);
        // 6: drain, then en falls mid-service
        ev_ready = 1'b1;
        n = 0;
        while (ev_valid && n < 20) begin step(1); n++; end
        ev_ready = 1'b0;
        chk("t6_count8", n, 8);
        w2 = wr2_cnt;
        make_edge(1'b0);
        step(1);
        step(4);
        en = 1'b0;
        step(7);
        chk("t6_wr2_cnt", wr2_cnt, w2 + 1);
        chk("t6_wr2_data", wr2_data, 0);
        chk("t6_mask_after_push", wr2_cyc, clr_cyc + 5);
        chk("t6_valid", ev_valid, 1);
        chk("t6_level", ev_data[0], 0);
        bc = bus_cnt;
        force_irq = 1'b1; step(5); force_irq = 1'b0;
        make_edge(1'b1);
        step(5);
        chk("t6_no_bus", bus_cnt, bc);
        chk("t6_busy", busy, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
